// File: rtl/csr_trap_sequencer.sv
// csr_trap_sequencer: arbitrates the machine-mode CSR write port between
// decoded Zicsr instructions and the trap-entry / MRET write sequences, and
// issues the fetch redirect that ends each sequence.
module csr_trap_sequencer #(
    parameter int XLEN        = 32,
    parameter bit VECTOR_EN   = 1'b1,
    parameter bit WRITE_MTVAL = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [XLEN-1:0] trap_tval,
    input  logic            mret_valid,
    input  logic            csr_op_valid,
    input  logic            csr_op_we,
    input  logic [11:0]     csr_op_addr,
    input  logic [XLEN-1:0] csr_op_wdata,
    output logic            csr_op_ready,
    input  logic [XLEN-1:0] csr_mstatus_i,
    input  logic [XLEN-1:0] csr_mtvec_i,
    input  logic [XLEN-1:0] csr_mepc_i,
    output logic            csr_we,
    output logic [11:0]     csr_waddr,
    output logic [XLEN-1:0] csr_wdata,
    output logic            stall,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);

    localparam logic [11:0]     ADDR_MSTATUS = 12'h300;
    localparam logic [11:0]     ADDR_MEPC    = 12'h341;
    localparam logic [11:0]     ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0]     ADDR_MTVAL   = 12'h343;
    localparam logic [XLEN-1:0] LOW2_MASK    = XLEN'(3);

    typedef enum logic [2:0] {
        IDLE,
        T_MEPC,
        T_MCAUSE,
        T_MTVAL,
        T_MSTATUS,
        T_JUMP,
        R_MSTATUS,
        R_JUMP
    } state_t;

    state_t          state;
    logic [XLEN-1:0] cause_q;
    logic [XLEN-1:0] tval_q;
    logic            seq_we;
    logic [11:0]     seq_waddr;
    logic [XLEN-1:0] seq_wdata;
    logic            redir_vld;
    logic [XLEN-1:0] redir_pc;
    logic            op_write;

    // Clear the two low bits: PCs and MTVEC base are word aligned.
    function automatic logic [XLEN-1:0] align(input logic [XLEN-1:0] v);
        return v & ~LOW2_MASK;
    endfunction

    // Trap entry: stash MIE into MPIE, disable interrupts, previous mode = M.
    function automatic logic [XLEN-1:0] trap_mstatus(input logic [XLEN-1:0] m);
        logic [XLEN-1:0] r;
        r        = m;
        r[7]     = m[3];
        r[3]     = 1'b0;
        r[12:11] = 2'b11;
        return r;
    endfunction

    // MRET: restore MIE from MPIE, set MPIE, keep MPP at M (M-only core).
    function automatic logic [XLEN-1:0] mret_mstatus(input logic [XLEN-1:0] m);
        logic [XLEN-1:0] r;
        r        = m;
        r[3]     = m[7];
        r[7]     = 1'b1;
        r[12:11] = 2'b11;
        return r;
    endfunction

    // Handler address; only interrupts in mode 01 are vectored, modes 10/11 act as direct.
    function automatic logic [XLEN-1:0] trap_target(input logic [XLEN-1:0] mtvec,
                                                    input logic [XLEN-1:0] cause);
        logic [XLEN-1:0] base;
        base = align(mtvec);
        if (VECTOR_EN && (mtvec[1:0] == 2'b01) && cause[XLEN-1])
            return base + {{(XLEN-7){1'b0}}, cause[4:0], 2'b00};
        return base;
    endfunction

    // Sequencer FSM; the write/redirect for each state is registered on entry to it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cause_q   <= '0;
            tval_q    <= '0;
            seq_we    <= 1'b0;
            seq_waddr <= '0;
            seq_wdata <= '0;
            redir_vld <= 1'b0;
            redir_pc  <= '0;
        end else begin
            seq_we    <= 1'b0;
            seq_waddr <= '0;
            seq_wdata <= '0;
            redir_vld <= 1'b0;
            redir_pc  <= '0;
            case (state)
                IDLE: begin
                    if (trap_valid) begin
                        state     <= T_MEPC;
                        cause_q   <= trap_cause;
                        tval_q    <= trap_tval;
                        seq_we    <= 1'b1;
                        seq_waddr <= ADDR_MEPC;
                        seq_wdata <= align(trap_pc);
                    end else if (mret_valid) begin
                        state     <= R_MSTATUS;
                        seq_we    <= 1'b1;
                        seq_waddr <= ADDR_MSTATUS;
                        seq_wdata <= mret_mstatus(csr_mstatus_i);
                    end
                end
                T_MEPC: begin
                    state     <= T_MCAUSE;
                    seq_we    <= 1'b1;
                    seq_waddr <= ADDR_MCAUSE;
                    seq_wdata <= cause_q;
                end
                T_MCAUSE: begin
                    seq_we <= 1'b1;
                    if (WRITE_MTVAL) begin
                        state     <= T_MTVAL;
                        seq_waddr <= ADDR_MTVAL;
                        seq_wdata <= tval_q;
                    end else begin
                        state     <= T_MSTATUS;
                        seq_waddr <= ADDR_MSTATUS;
                        seq_wdata <= trap_mstatus(csr_mstatus_i);
                    end
                end
                T_MTVAL: begin
                    state     <= T_MSTATUS;
                    seq_we    <= 1'b1;
                    seq_waddr <= ADDR_MSTATUS;
                    seq_wdata <= trap_mstatus(csr_mstatus_i);
                end
                T_MSTATUS: begin
                    state     <= T_JUMP;
                    redir_vld <= 1'b1;
                    redir_pc  <= trap_target(csr_mtvec_i, cause_q);
                end
                R_MSTATUS: begin
                    state     <= R_JUMP;
                    redir_vld <= 1'b1;
                    redir_pc  <= align(csr_mepc_i);
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Write-port mux: sequence writes only happen outside IDLE, CSR ops only in IDLE.
    always_comb begin
        csr_op_ready   = rst_n & (state == IDLE) & ~trap_valid & ~mret_valid;
        op_write       = csr_op_ready & csr_op_valid & csr_op_we;
        csr_we         = seq_we | op_write;
        csr_waddr      = '0;
        csr_wdata      = '0;
        if (seq_we) begin
            csr_waddr = seq_waddr;
            csr_wdata = seq_wdata;
        end else if (op_write) begin
            csr_waddr = csr_op_addr;
            csr_wdata = csr_op_wdata;
        end
        stall          = rst_n & ((state != IDLE) | trap_valid | mret_valid);
        redirect_valid = redir_vld;
        redirect_pc    = redir_pc;
    end

    // Upstream is frozen by stall, so no new trap/MRET may arrive mid-sequence.
    no_event_while_busy: assert property (@(posedge clk) disable iff (!rst_n)
        (state != IDLE) |-> !(trap_valid || mret_valid));

endmodule

// File: tb/tb_csr_trap_sequencer.sv
// Directed bench for csr_trap_sequencer: a default instance and a second
// instance with VECTOR_EN=0, WRITE_MTVAL=0 sharing the same stimulus.
module tb_csr_trap_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tv, mv, ov, owe;
    logic [11:0] oa;
    logic [31:0] owd, cause, pc, tval, mst, mtvec, mepc;

    logic        rdy, we, st, rv;
    logic [11:0] wa;
    logic [31:0] wd, rpc;
    logic        rdy2, we2, st2, rv2;
    logic [11:0] wa2;
    logic [31:0] wd2, rpc2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    csr_trap_sequencer #(.XLEN(32), .VECTOR_EN(1'b1), .WRITE_MTVAL(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .trap_valid(tv), .trap_cause(cause), .trap_pc(pc), .trap_tval(tval),
        .mret_valid(mv),
        .csr_op_valid(ov), .csr_op_we(owe), .csr_op_addr(oa), .csr_op_wdata(owd),
        .csr_op_ready(rdy),
        .csr_mstatus_i(mst), .csr_mtvec_i(mtvec), .csr_mepc_i(mepc),
        .csr_we(we), .csr_waddr(wa), .csr_wdata(wd),
        .stall(st), .redirect_valid(rv), .redirect_pc(rpc)
    );

    csr_trap_sequencer #(.XLEN(32), .VECTOR_EN(1'b0), .WRITE_MTVAL(1'b0)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .trap_valid(tv), .trap_cause(cause), .trap_pc(pc), .trap_tval(tval),
        .mret_valid(mv),
        .csr_op_valid(ov), .csr_op_we(owe), .csr_op_addr(oa), .csr_op_wdata(owd),
        .csr_op_ready(rdy2),
        .csr_mstatus_i(mst), .csr_mtvec_i(mtvec), .csr_mepc_i(mepc),
        .csr_we(we2), .csr_waddr(wa2), .csr_wdata(wd2),
        .stall(st2), .redirect_valid(rv2), .redirect_pc(rpc2)
    );

    typedef struct {
        logic        tv, mv, ov, owe;
        logic [11:0] oa;
        logic [31:0] owd, cause, pc, tval, mst, mtvec, mepc;
        logic        rdy, we;
        logic [11:0] wa;
        logic [31:0] wd;
        logic        st, rv;
        logic [31:0] rpc;
        logic        we2;
        logic [11:0] wa2;
        logic [31:0] wd2;
        logic        rv2;
        logic [31:0] rpc2;
    } vec_t;

    vec_t        vecs[$];
    string       names[$];
    logic [31:0] env_mst, env_mtvec, env_mepc;

    task automatic env(input logic [31:0] m, input logic [31:0] t, input logic [31:0] e);
        env_mst   = m;
        env_mtvec = t;
        env_mepc  = e;
    endtask

    task automatic row(input string nm,
                       input logic i_tv, input logic i_mv, input logic i_ov, input logic i_owe,
                       input logic [11:0] i_oa, input logic [31:0] i_owd,
                       input logic [31:0] i_cause, input logic [31:0] i_pc, input logic [31:0] i_tval,
                       input logic e_rdy, input logic e_we, input logic [11:0] e_wa,
                       input logic [31:0] e_wd, input logic e_st, input logic e_rv,
                       input logic [31:0] e_rpc,
                       input logic e_we2, input logic [11:0] e_wa2, input logic [31:0] e_wd2,
                       input logic e_rv2, input logic [31:0] e_rpc2);
        vec_t v;
        v.tv = i_tv; v.mv = i_mv; v.ov = i_ov; v.owe = i_owe;
        v.oa = i_oa; v.owd = i_owd; v.cause = i_cause; v.pc = i_pc; v.tval = i_tval;
        v.mst = env_mst; v.mtvec = env_mtvec; v.mepc = env_mepc;
        v.rdy = e_rdy; v.we = e_we; v.wa = e_wa; v.wd = e_wd;
        v.st = e_st; v.rv = e_rv; v.rpc = e_rpc;
        v.we2 = e_we2; v.wa2 = e_wa2; v.wd2 = e_wd2; v.rv2 = e_rv2; v.rpc2 = e_rpc2;
        vecs.push_back(v);
        names.push_back(nm);
    endtask

    task automatic check(input string nm, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic quiet();
        tv = 0; mv = 0; ov = 0; owe = 0; oa = '0; owd = '0;
        cause = '0; pc = '0; tval = '0;
    endtask

    initial begin
        // rows: name, tv mv ov owe oa owd cause pc tval | rdy we wa wd st rv rpc | we2 wa2 wd2 rv2 rpc2
        env(32'h0, 32'h0, 32'h0);
        row("idle",      0,0,0,0, 12'h000, 32'h0,  32'h0, 32'h0, 32'h0,  1,0,12'h000,32'h0,0,0,32'h0,  0,12'h000,32'h0,0,32'h0);
        row("csr_op",    0,0,1,1, 12'h305, 32'h80, 32'h0, 32'h0, 32'h0,  1,1,12'h305,32'h80,0,0,32'h0, 1,12'h305,32'h80,0,32'h0);
        row("csr_nowe",  0,0,1,0, 12'h340, 32'h55, 32'h0, 32'h0, 32'h0,  1,0,12'h000,32'h0,0,0,32'h0,  0,12'h000,32'h0,0,32'h0);
        env(32'h8, 32'h100, 32'h0);
        row("trap_acc",  1,0,0,0, 12'h000, 32'h0, 32'h2, 32'h1006, 32'hDEAD, 0,0,12'h000,32'h0,1,0,32'h0, 0,12'h000,32'h0,0,32'h0);
        row("t_mepc",    0,0,0,0, 12'h000, 32'h0, 32'h0, 32'h0, 32'h0,  0,1,12'h341,32'h1004,1,0,32'h0, 1,12'h341,32'h1004,0,32'h0);
        row("t_mcause",  0,0,0,0, 12'h000, 32'h0, 32'h0, 32'h0, 32'h0,  0,1,12'h342,32'h2,1,0,32'h0,    1,12'h342,32'h2,0,32'h0);
        row("t_mtval",   0,0,0,0, 12'h000, 32'h0, 32'h0, 32'h0, 32'h0,  0,1,12'h343,32'hDEAD,1,0,32'h0, 1,12'h300,32'h1880,0,32'h0);
        row("t_mstatus", 0,0,0,0, 12'h000, 32'h0, 32'h0, 32'h0, 32'h0,  0,1,12'h300,32'h1880,1,0,32'h0, 0,12'h000,32'h0,1,32'h100);
        row("t_jump",    0,0,0,0, 12'h000, 32'h0, 32'h0, 32'h0, 32'h0,  0,0,12'h000,32'h0,1,1,32'h100,  0,12'h000,32'h0,0,32'h0);
        row("trap_done", 0,0,0,0, 12'h000, 32'h0, 32'h0, 32'h0, 32'h0,  1,0,12'h000,32'h0,0,0,32'h0,    0,12'h000,32'h0,0,32'h0);
        env(32'h1880, 32'h0, 32'h2002);
        row("mret_acc",  0,1,0,0, 12'h000, 32'h0, 32'h0, 32'h0, 32'h0,  0,0,12'h000,32'h0,1,0,32'h0,    0,12'h000,32'h0,0,32'h0);
        row("r_mstatus", 0,0,0,0, 12'h000, 32'h0, 32'h0, 32'h0, 32'h0,  0,1,12'h300,32'h1888,1,0,32'h0, 1,12'h300,32'h1888,0,32'h0);
        row("r_jump",    0,0,0,0, 12'h000, 32'h0, 32'h0, 32'h0, 32'h0,  0,0,12'h000,32'h0,1,1,32'h2000, 0,12'h000,32'h0,1,32'h2000);
        row("mret_done", 0,0,0,0, 12'h000, 32'h0, 32'h0, 32'h0, 32'h0,  1,0,12'h000,32'h0,0,0,32'h0,    0,12'h000,32'h0,0,32'h0);
        env(32'h0, 32'h201, 32'h0);
        row("all_three", 1,1,1,1, 12'h305, 32'h80, 32'h80000007, 32'h3000, 32'h0, 0,0,12'h000,32'h0,1,0,32'h0, 0,12'h000,32'h0,0,32'h0);
        row("v_mepc",    0,0,0,0, 12'h000, 32'h0, 32'h0, 32'h0, 32'h0,  0,1,12'h341,32'h3000,1,0,32'h0, 1,12'h341,32'h3000,0,32'h0);
        row("v_mcause",  0,0,0,0, 12'h000, 32'h0, 32'h0, 32'h0, 32'h0,  0,1,12'h342,32'h80000007,1,0,32'h0, 1,12'h342,32'h80000007,0,32'h0);
        row("v_mtval",   0,0,0,0, 12'h000, 32'h0, 32'h0, 32'h0, 32'h0,  0,1,12'h343,32'h0,1,0,32'h0,    1,12'h300,32'h1800,0,32'h0);
        row("v_mstatus", 0,0,0,0, 12'h000, 32'h0, 32'h0, 32'h0, 32'h0,  0,1,12'h300,32'h1800,1,0,32'h0, 0,12'h000,32'h0,1,32'h200);
        row("v_jump",    0,0,0,0, 12'h000, 32'h0, 32'h0, 32'h0, 32'h0,  0,0,12'h000,32'h0,1,1,32'h21C,  0,12'h000,32'h0,0,32'h0);
        row("mret_lost", 0,0,1,1, 12'h305, 32'h1C, 32'h0, 32'h0, 32'h0, 1,1,12'h305,32'h1C,0,0,32'h0,  1,12'h305,32'h1C,0,32'h0);

        // Reset state: every output low even with requests present
        rst_n = 1'b0;
        quiet();
        mst = '0; mtvec = '0; mepc = '0;
        tv = 1; mv = 1; ov = 1; owe = 1; oa = 12'h305; owd = 32'h80;
        #3;
        check("reset", {rdy, we, wa, wd, st, rv, rpc}, 80'h0);
        check("reset2", {rdy2, we2, wa2, wd2, st2, rv2, rpc2}, 80'h0);
        quiet();
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            tv = vecs[i].tv; mv = vecs[i].mv; ov = vecs[i].ov; owe = vecs[i].owe;
            oa = vecs[i].oa; owd = vecs[i].owd;
            cause = vecs[i].cause; pc = vecs[i].pc; tval = vecs[i].tval;
            mst = vecs[i].mst; mtvec = vecs[i].mtvec; mepc = vecs[i].mepc;
            @(negedge clk);
            check(names[i], {rdy, we, wa, wd, st, rv, rpc},
                  {vecs[i].rdy, vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].st, vecs[i].rv, vecs[i].rpc});
            check({names[i], "_nv"}, {2'b00, we2, wa2, wd2, rv2, rpc2},
                  {2'b00, vecs[i].we2, vecs[i].wa2, vecs[i].wd2, vecs[i].rv2, vecs[i].rpc2});
        end

        // Reset asserted in T_MCAUSE aborts the sequence at once
        @(posedge clk);
        #1;
        quiet();
        mst = 32'h8; mtvec = 32'h100; mepc = '0;
        tv = 1; cause = 32'h5; pc = 32'h40;
        @(negedge clk);
        check("mr_acc", {78'h0, rdy, st}, {78'h0, 1'b0, 1'b1});
        @(posedge clk);
        #1;
        tv = 0; cause = '0; pc = '0;
        @(negedge clk);
        check("mr_mepc", {35'h0, we, wa, wd}, {35'h0, 1'b1, 12'h341, 32'h40});
        @(posedge clk);
        #1;
        ov = 1; owe = 1; oa = 12'h305; owd = 32'h77;
        @(negedge clk);
        check("mr_mcause", {33'h0, rdy, we, wa, wd, st}, {33'h0, 1'b0, 1'b1, 12'h342, 32'h5, 1'b1});
        #1;
        rst_n = 1'b0;
        #1;
        check("mr_async", {rdy, we, wa, wd, st, rv, rpc}, 80'h0);
        check("mr_async2", {rdy2, we2, wa2, wd2, st2, rv2, rpc2}, 80'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mr_release", {32'h0, rdy, we, wa, wd, st, rv},
              {32'h0, 1'b1, 1'b1, 12'h305, 32'h77, 1'b0, 1'b0});
        check("mr_release2", {33'h0, rdy2, we2, wa2, wd2, st2},
              {33'h0, 1'b1, 1'b1, 12'h305, 32'h77, 1'b0});
        @(posedge clk);
        #1;
        quiet();
        @(negedge clk);
        check("mr_idle", {76'h0, rdy, we, st, rv}, {76'h0, 1'b1, 1'b0, 1'b0, 1'b0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
